// File: rtl/data_mem_ctrl_pkg.sv
// Shared load/store encodings, FSM state type and byte-lane helpers for the MEM-stage data-memory controller.
package data_mem_ctrl_pkg;

    // Enable-bit positions inside the mem_read / mem_write codes from control_unit
    localparam int LD_EN_BIT = 3;
    localparam int ST_EN_BIT = 2;

    // Load funct3 codes (mem_read[2:0])
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3[1:0] codes (mem_write[1:0])
    localparam logic [1:0] F3_SB = 2'b00;
    localparam logic [1:0] F3_SH = 2'b01;
    localparam logic [1:0] F3_SW = 2'b10;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_e;

    // Operation details latched at the start of an access, used when the ack arrives
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] addr_lo;
    } op_t;

    // Access size from funct3[1:0]; reserved encodings fall back to a full word
    function automatic size_e f3_size(input logic [1:0] f);
        case (f)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_H:    return a[0];
            SZ_W:    return |a;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Load extraction: picks the addressed byte/half out of the read word and sign- or zero-extends it.
module load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [3:0][7:0] lanes;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            sgn;

    assign lanes = rdata;

    // Lane select and extension; funct3[2] set means unsigned
    always_comb begin
        byte_v = lanes[addr_lo];
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sgn    = ~funct3[2];
        case (f3_size(funct3[1:0]))
            SZ_B:    data = {{24{sgn & byte_v[7]}}, byte_v};
            SZ_H:    data = {{16{sgn & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: one req/ack word transaction per load/store,
// byte enables and store lane replication, timeout abort, load extension.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            mem_read,
    input  logic [2:0]            mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  done,
    output logic                  misalign,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    op_t                   op_q, op_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-3:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  done_q, done_d;
    logic                  misalign_q, misalign_d;
    logic                  bus_err_q, bus_err_d;

    logic        is_load, is_store, access, mis;
    logic [2:0]  f3;
    size_e       sz;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [31:0] ld_ext;

    // Decode the incoming op; a load beats a simultaneous store
    always_comb begin
        is_load  = mem_read[LD_EN_BIT];
        is_store = mem_write[ST_EN_BIT] & ~is_load;
        access   = is_load | is_store;
        f3       = is_load ? mem_read[2:0] : {1'b0, mem_write[1:0]};
        sz       = f3_size(f3[1:0]);
        mis      = is_misaligned(sz, addr[1:0]);
        be_new   = byte_en(sz, addr[1:0]);
        case (sz)
            SZ_B:    wd_new = {4{wdata[7:0]}};
            SZ_H:    wd_new = {2{wdata[15:0]}};
            default: wd_new = wdata;
        endcase
        if (!is_store)
            wd_new = '0;
    end

    load_align u_load_align (
        .rdata   (mem_rdata),
        .addr_lo (op_q.addr_lo),
        .funct3  (op_q.funct3),
        .data    (ld_ext)
    );

    // Next-state and registered-output logic for IDLE -> REQ -> DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (mis) begin
                        // No bus cycle: report straight away
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        op_d        = '{funct3: f3, addr_lo: addr[1:0]};
                        mem_we_d    = is_store;
                        mem_addr_d  = addr[ADDR_WIDTH-1:2];
                        mem_be_d    = be_new;
                        mem_wdata_d = wd_new;
                        mem_req_d   = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    if (!mem_we_q)
                        load_data_d = ld_ext;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    load_data_d = '0;
                    bus_err_d   = 1'b1;
                    mem_req_d   = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any open transaction at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Stall is combinational so the pipeline freezes in the same cycle the access shows up
    always_comb begin
        stall = (state_q == ST_REQ) || ((state_q == ST_IDLE) && access);
    end

    assign load_data = load_data_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: vector table driven through a small memory responder,
// done-time results checked against a scoreboard queue, plus reset-abort sequence.
module tb_data_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    data_mem_ctrl #(.TIMEOUT(TO), .ADDR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .load_data (load_data),
        .done      (done),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;   // ack in this REQ cycle (1-based); 0 = never
        int          n_stall;
        int          n_req;
        logic        we;
        logic [3:0]  be;
        logic        chk_wd;
        logic [31:0] wd;
        logic        chk_ld;
        logic [31:0] ld;
        logic        mis;
        logic        err;
    } vec_t;

    typedef struct {
        string       name;
        logic        chk_ld;
        logic [31:0] ld;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    function automatic vec_t mk(input string n, input logic [3:0] rd, input logic [2:0] wr,
                                input logic [31:0] a, input logic [31:0] wd_in, input logic [31:0] rdat,
                                input int ack, input int nst, input int nrq, input logic we,
                                input logic [3:0] be, input logic cwd, input logic [31:0] wd,
                                input logic cld, input logic [31:0] ld, input logic mis, input logic err);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd_in; v.rdata = rdat;
        v.ack_dly = ack; v.n_stall = nst; v.n_req = nrq; v.we = we; v.be = be;
        v.chk_wd = cwd; v.wd = wd; v.chk_ld = cld; v.ld = ld; v.mis = mis; v.err = err;
        return v;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no pending access");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, ".misalign"}, {31'b0, misalign}, {31'b0, e.mis});
                chk({e.name, ".bus_err"}, {31'b0, bus_err}, {31'b0, e.err});
                if (e.chk_ld)
                    chk({e.name, ".load_data"}, load_data, e.ld);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int  stall_n = 0;
        int  req_n   = 0;
        bit  seen    = 0;
        exp_t e;
        @(posedge clk); #1;
        mem_read  = v.rd;
        mem_write = v.wr;
        addr      = v.addr;
        wdata     = v.wdata;
        mem_ack   = 1'b0;
        e.name = v.name; e.chk_ld = v.chk_ld; e.ld = v.ld; e.mis = v.mis; e.err = v.err;
        sb_q.push_back(e);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (mem_req) begin
                req_n++;
                chk({v.name, ".mem_we"}, {31'b0, mem_we}, {31'b0, v.we});
                chk({v.name, ".mem_be"}, {28'b0, mem_be}, {28'b0, v.be});
                chk({v.name, ".mem_addr"}, {2'b0, mem_addr}, v.addr >> 2);
                if (v.chk_wd)
                    chk({v.name, ".mem_wdata"}, mem_wdata, v.wd);
                if (req_n == v.ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (done) begin
                seen = 1;
            end else begin
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no done in 40 cycles, expected done", v.name);
        end
        chk({v.name, ".stall_cycles"}, stall_n, v.n_stall);
        chk({v.name, ".req_cycles"}, req_n, v.n_req);
        // Pipeline advances after DONE; flags must clear, load_data must hold
        @(posedge clk); #1;
        mem_read  = 4'b0;
        mem_write = 3'b0;
        addr      = $urandom;
        wdata     = $urandom;
        @(negedge clk);
        chk({v.name, ".flags_clear"}, {29'b0, done, misalign, bus_err}, 32'h0);
        chk({v.name, ".stall_idle"}, {31'b0, stall}, 32'h0);
        if (v.chk_ld)
            chk({v.name, ".load_hold"}, load_data, v.ld);
    endtask

    vec_t vt[16];

    initial begin
        vt[0]  = mk("lw",      4'b1010, 3'b000, 32'h100, 32'h0,        32'hDEADBEEF, 2, 3, 2, 1'b0, 4'hF, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        vt[1]  = mk("lb",      4'b1000, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1, 2, 1, 1'b0, 4'h8, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
        vt[2]  = mk("lbu",     4'b1100, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1, 2, 1, 1'b0, 4'h8, 1'b0, 32'h0,        1'b1, 32'h00000080, 1'b0, 1'b0);
        vt[3]  = mk("sh",      4'b0000, 3'b101, 32'h202, 32'h1234ABCD, 32'h0,        1, 2, 1, 1'b1, 4'hC, 1'b1, 32'hABCDABCD, 1'b1, 32'h00000080, 1'b0, 1'b0);
        vt[4]  = mk("lw_mis",  4'b1010, 3'b000, 32'h101, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
        vt[5]  = mk("sw_to",   4'b0000, 3'b110, 32'h400, 32'h11223344, 32'h0,        0, 5, 4, 1'b1, 4'hF, 1'b1, 32'h11223344, 1'b1, 32'h0,        1'b0, 1'b1);
        vt[6]  = mk("lh_hi",   4'b1001, 3'b000, 32'h102, 32'h0,        32'h80011234, 3, 4, 3, 1'b0, 4'hC, 1'b0, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 1'b0);
        vt[7]  = mk("lhu",     4'b1101, 3'b000, 32'h100, 32'h0,        32'h8001F00D, 1, 2, 1, 1'b0, 4'h3, 1'b0, 32'h0,        1'b1, 32'h0000F00D, 1'b0, 1'b0);
        vt[8]  = mk("lb1",     4'b1000, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 2, 1, 1'b0, 4'h2, 1'b0, 32'h0,        1'b1, 32'h0000007F, 1'b0, 1'b0);
        vt[9]  = mk("sb",      4'b0000, 3'b100, 32'h203, 32'hAABBCC5A, 32'h0,        1, 2, 1, 1'b1, 4'h8, 1'b1, 32'h5A5A5A5A, 1'b1, 32'h0000007F, 1'b0, 1'b0);
        vt[10] = mk("lh_mis",  4'b1001, 3'b000, 32'h103, 32'h0,        32'h0,        0, 1, 0, 1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
        vt[11] = mk("sw_mis",  4'b0000, 3'b110, 32'h206, 32'h0000FFFF, 32'h0,        0, 1, 0, 1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0);
        vt[12] = mk("ld_wins", 4'b1010, 3'b110, 32'h300, 32'h55555555, 32'hCAFEF00D, 4, 5, 4, 1'b0, 4'hF, 1'b0, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
        vt[13] = mk("lw_rsv",  4'b1011, 3'b000, 32'h104, 32'h0,        32'h13572468, 1, 2, 1, 1'b0, 4'hF, 1'b0, 32'h0,        1'b1, 32'h13572468, 1'b0, 1'b0);
        vt[14] = mk("lb0",     4'b1000, 3'b000, 32'h100, 32'h0,        32'h000000FF, 1, 2, 1, 1'b0, 4'h1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        vt[15] = mk("sw",      4'b0000, 3'b110, 32'h204, 32'h89ABCDEF, 32'h0,        2, 3, 2, 1'b1, 4'hF, 1'b1, 32'h89ABCDEF, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);

        reset     = 1'b1;
        mem_read  = 4'b0;
        mem_write = 3'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst.flags", {26'b0, stall, done, misalign, bus_err, mem_req, mem_we}, 32'h0);
        chk("rst.load_data", load_data, 32'h0);
        chk("rst.mem_be", {28'b0, mem_be}, 32'h0);
        chk("rst.mem_addr", {2'b0, mem_addr}, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vt[i]) run_vec(vt[i]);

        // Reset in the middle of a REQ: mem_req drops at once, a late ack is ignored
        @(posedge clk); #1;
        mem_read = 4'b1010;
        addr     = 32'h500;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid.req_before", {31'b0, mem_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.req_dropped", {31'b0, mem_req}, 32'h0);
        mem_read = 4'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        chk("rstmid.late_ack", {30'b0, done, mem_req}, 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rstmid.after", {29'b0, done, mem_req, stall}, 32'h0);
        chk("rstmid.load_data", load_data, 32'h0);

        run_vec(mk("lw_post", 4'b1010, 3'b000, 32'h108, 32'h0, 32'h0BADF00D, 1, 2, 1, 1'b0, 4'hF, 1'b0, 32'h0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0));

        chk("sb.drained", sb_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
